la_trigger_capture: RTL and testbench
=====================================

// Module: la_trigger_capture
// PURPOSE
//  Capture controller directly downstream of the test-pattern source / probe input.
//  Watches a sample stream, applies a mask/value/edge trigger and writes a
//  pre-/post-trigger window into a circular sample RAM (DATA_WIDTH x 2^ADDR_WIDTH).
//  Provides the trigger address and the window start address to the readout logic.
// PARAMETERS
//  DATA_WIDTH  8   sample width
//  ADDR_WIDTH  10  sample RAM address width (depth = 2^ADDR_WIDTH)
// PORTS
//  clk           in   1           single clock, all logic rising-edge
//  rst           in   1           asynchronous, active-high reset
//  arm           in   1           1-cycle pulse: start capture (honoured in IDLE/DONE only)
//  abort         in   1           return to IDLE from any state
//  sample_valid  in   1           sample_data qualifier
//  sample_data   in   DATA_WIDTH  probe sample
//  trig_mask     in   DATA_WIDTH  1 = bit takes part in level compare
//  trig_value    in   DATA_WIDTH  level-compare value
//  trig_edge     in   DATA_WIDTH  1 = a change on this bit is required
//  pre_count     in   ADDR_WIDTH  samples kept before the trigger
//  post_count    in   ADDR_WIDTH  samples kept after the trigger sample
//  wr_en         out  1           RAM write strobe
//  wr_addr       out  ADDR_WIDTH  RAM write address
//  wr_data       out  DATA_WIDTH  RAM write data
//  trig_addr     out  ADDR_WIDTH  address of the trigger sample
//  start_addr    out  ADDR_WIDTH  trig_addr - pre_count (mod depth)
//  triggered     out  1           trigger seen in this capture
//  done          out  1           window complete
//  state         out  3           0 IDLE, 1 PRE_FILL, 2 ARMED, 3 POST, 4 DONE
// BEHAVIOUR
//  - Reset: state IDLE; all outputs, pointer, counters and prev-sample register are 0.
//  - arm in IDLE/DONE: latch pre_count, post_count, mask/value/edge. Clear the pointer,
//    triggered, done and the prev_valid flag.
//    Go to PRE_FILL if pre_count != 0, else ARMED. A sample in the arm cycle is not captured.
//  - Otherwise arm is ignored. Abort beats arm in the same cycle.
//    Abort clears triggered and done; RAM contents are left as they are.
//  - Accepted sample = sample_valid in PRE_FILL/ARMED/POST. Each accepted sample produces a
//    write 1 cycle later: wr_en=1, wr_addr=pointer, wr_data=sample. pointer+1 mod 2^ADDR_WIDTH.
//    wr_en is 0 in all other cycles.
//  - PRE_FILL: count accepted samples. After the pre_count-th sample go to ARMED.
//    The trigger is not evaluated in PRE_FILL.
//  - Trigger (ARMED, accepted sample) fires when both of these hold:
//    ((sample^trig_value)&trig_mask)==0, and
//    (trig_edge==0 or (prev_valid and ((sample^prev)&trig_edge)!=0)).
//    prev/prev_valid update on every accepted sample, so the first sample after arm never
//    edge-triggers.
//  - On trigger: the trigger sample is written. trig_addr = its address, start_addr computed.
//    triggered=1 (registered together with the write). post counter = latched post_count.
//    Go to POST, or to DONE if post_count==0.
//  - POST: after post_count further accepted samples go to DONE. done=1 with the last write.
//  - DONE: done and triggered hold until arm or abort.
//  - pre_count+post_count+1 > depth: the buffer wraps and oldest data is overwritten.
//    No error is flagged; software limits the window.
//  - Address arithmetic is unsigned modulo 2^ADDR_WIDTH everywhere.
// TESTING
//  1 pre=4,post=3,mask=FF,value=10, ramp 0..: writes 0..3 (PRE), ARMED 4.., trigger at 0x10
//    addr 16; writes 0x11..0x13; done after last write, trig_addr=16, start_addr=12.
//  2 Edge: mask=00, edge=01, pre=0, first sample 0x01 then 0x01,0x00: no trigger on
//    the 1st/2nd sample, trigger on 0x00 (3rd), trig_addr=2.
//  3 Wrap: AW=4, pre=2, post=2, value never matches for 20 samples then matches: wr_addr wraps 15->0,
//    trig_addr=(20+0)mod16=4... check start_addr=trig_addr-2 mod 16.
//  4 Abort in POST: state->IDLE next cycle, wr_en stops, done=0, triggered=0;
//    arm+abort same cycle stays IDLE.
//  5 Gaps: sample_valid toggling 1/0 -> counts and pointer advance on valid cycles only.
//    post=0 -> done together with the trigger write.
//  6 Reset mid-ARMED: all outputs 0 and state IDLE immediately. Re-arm after DONE restarts
//    at wr_addr 0.

Source files
------------

// File: rtl/la_trigger_capture_if.sv
// la_trigger_capture_if
//   Groups the capture controller's streaming signals.
//   Sample side : sample_valid, sample_data (probe -> capture)
//   RAM side    : wr_en, wr_addr, wr_data   (capture -> sample RAM)
//   slave  : the capture controller (consumes samples, drives RAM writes)
//   master : the probe source / RAM model (drives samples, observes writes)
interface la_trigger_capture_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output sample_valid, sample_data,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  sample_valid, sample_data,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/la_trigger_capture.sv
// la_trigger_capture
//   Logic-analyser capture controller. Applies a mask/value/edge trigger to a
//   sample stream and writes a pre-/post-trigger window into a circular
//   sample RAM of depth 2^ADDR_WIDTH.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_arm, i_abort      start capture (IDLE/DONE only) / return to IDLE
//   i_trig_mask/value   level compare (mask bit 1 = bit takes part)
//   i_trig_edge         bits on which a change is required
//   i_pre_count         samples kept before the trigger
//   i_post_count        samples kept after the trigger sample
//   bus (slave)         sample stream in, RAM write strobe/addr/data out
//   o_trig_addr         RAM address of the trigger sample
//   o_start_addr        o_trig_addr - pre_count (mod depth)
//   o_triggered, o_done trigger seen / window complete
//   o_state             0 IDLE, 1 PRE_FILL, 2 ARMED, 3 POST, 4 DONE
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | not capturing
// PRE_FILL | writing the first pre_count samples, trigger ignored
// ARMED    | writing samples, evaluating the trigger on each one
// POST     | trigger seen, writing post_count further samples
// DONE     | window complete, done/triggered held until arm/abort
module la_trigger_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_arm,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] i_trig_mask,
  input  logic [DATA_WIDTH-1:0] i_trig_value,
  input  logic [DATA_WIDTH-1:0] i_trig_edge,
  input  logic [ADDR_WIDTH-1:0] i_pre_count,
  input  logic [ADDR_WIDTH-1:0] i_post_count,
  la_trigger_capture_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] o_trig_addr,
  output logic [ADDR_WIDTH-1:0] o_start_addr,
  output logic                  o_triggered,
  output logic                  o_done,
  output logic [2:0]            o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_pre;
  logic [ADDR_WIDTH-1:0] r_post;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_value;
  logic [DATA_WIDTH-1:0] r_edge;
  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_prev_valid;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic [ADDR_WIDTH-1:0] r_start_addr;
  logic                  r_triggered;
  logic                  r_done;

  logic w_level_ok;
  logic w_edge_ok;
  logic w_hit;

  assign w_level_ok = ((bus.sample_data ^ r_value) & r_mask) == '0;
  // prev_valid is cleared on arm, so the first sample of a capture can never edge-trigger
  assign w_edge_ok  = (r_edge == '0) ||
                      (r_prev_valid && (((bus.sample_data ^ r_prev) & r_edge) != '0));
  assign w_hit      = w_level_ok && w_edge_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_pre        <= '0;
      r_post       <= '0;
      r_mask       <= '0;
      r_value      <= '0;
      r_edge       <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_triggered  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (i_abort) begin
        r_state     <= S_IDLE;
        r_triggered <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (i_arm) begin
              r_pre        <= i_pre_count;
              r_post       <= i_post_count;
              r_mask       <= i_trig_mask;
              r_value      <= i_trig_value;
              r_edge       <= i_trig_edge;
              r_ptr        <= '0;
              r_prev_valid <= 1'b0;
              r_triggered  <= 1'b0;
              r_done       <= 1'b0;
              r_cnt        <= i_pre_count;
              r_state      <= (i_pre_count != '0) ? S_PRE : S_ARMED;
            end
          end
          S_PRE, S_ARMED, S_POST: begin
            if (bus.sample_valid) begin
              r_wr_en      <= 1'b1;
              r_wr_addr    <= r_ptr;
              r_wr_data    <= bus.sample_data;
              r_ptr        <= r_ptr + ADDR_ONE;
              r_prev       <= bus.sample_data;
              r_prev_valid <= 1'b1;
              if (r_state == S_PRE) begin
                if (r_cnt == ADDR_ONE) r_state <= S_ARMED;
                r_cnt <= r_cnt - ADDR_ONE;
              end else if (r_state == S_ARMED) begin
                if (w_hit) begin
                  r_trig_addr  <= r_ptr;
                  r_start_addr <= r_ptr - r_pre;
                  r_triggered  <= 1'b1;
                  if (r_post == '0) begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                  end else begin
                    r_cnt   <= r_post;
                    r_state <= S_POST;
                  end
                end
              end else begin
                if (r_cnt == ADDR_ONE) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end
                r_cnt <= r_cnt - ADDR_ONE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign o_trig_addr  = r_trig_addr;
  assign o_start_addr = r_start_addr;
  assign o_triggered  = r_triggered;
  assign o_done       = r_done;
  assign o_state      = r_state;

endmodule

// File: tb/tb_la_trigger_capture.sv
// Bench for la_trigger_capture. Two instances share one stimulus stream:
// u0 with a 1024-deep RAM, u1 with a 16-deep RAM so wrap-around is frequent.
module tb_la_trigger_capture;

  logic       clk;
  logic       rst;
  logic       t_arm, t_abort, t_valid;
  logic [7:0] t_data, t_mask, t_value, t_edge;
  logic [9:0] t_pre, t_post;

  int nerr = 0;
  int nchk = 0;

  la_trigger_capture_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus0();
  la_trigger_capture_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4))  bus1();

  assign bus0.sample_valid = t_valid;
  assign bus0.sample_data  = t_data;
  assign bus1.sample_valid = t_valid;
  assign bus1.sample_data  = t_data;

  logic [9:0] ta0, sa0;
  logic [3:0] ta1, sa1;
  logic       tr0, tr1, dn0, dn1;
  logic [2:0] st0, st1;

  la_trigger_capture #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) u0 (
    .clk(clk), .rst(rst), .i_arm(t_arm), .i_abort(t_abort),
    .i_trig_mask(t_mask), .i_trig_value(t_value), .i_trig_edge(t_edge),
    .i_pre_count(t_pre), .i_post_count(t_post), .bus(bus0),
    .o_trig_addr(ta0), .o_start_addr(sa0), .o_triggered(tr0), .o_done(dn0), .o_state(st0));

  la_trigger_capture #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u1 (
    .clk(clk), .rst(rst), .i_arm(t_arm), .i_abort(t_abort),
    .i_trig_mask(t_mask), .i_trig_value(t_value), .i_trig_edge(t_edge),
    .i_pre_count(t_pre[3:0]), .i_post_count(t_post[3:0]), .bus(bus1),
    .o_trig_addr(ta1), .o_start_addr(sa1), .o_triggered(tr1), .o_done(dn1), .o_state(st1));

  // DUT outputs gathered per instance
  int d_st[2], d_en[2], d_addr[2], d_data[2], d_ta[2], d_sa[2], d_tr[2], d_dn[2];
  always_comb begin
    d_st[0] = int'(st0);   d_st[1] = int'(st1);
    d_en[0] = int'(bus0.wr_en); d_en[1] = int'(bus1.wr_en);
    d_addr[0] = int'(bus0.wr_addr); d_addr[1] = int'(bus1.wr_addr);
    d_data[0] = int'(bus0.wr_data); d_data[1] = int'(bus1.wr_data);
    d_ta[0] = int'(ta0);   d_ta[1] = int'(ta1);
    d_sa[0] = int'(sa0);   d_sa[1] = int'(sa1);
    d_tr[0] = int'(tr0);   d_tr[1] = int'(tr1);
    d_dn[0] = int'(dn0);   d_dn[1] = int'(dn1);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A capture is described by how many samples were accepted since arm (m_n)
  // and at which sample index the trigger fired (m_tn, -1 = not yet).
  int         m_act[2], m_n[2], m_tn[2], m_pre[2], m_post[2], m_pv[2];
  logic [7:0] m_mask[2], m_val[2], m_edge[2], m_prev[2];
  int         e_en[2], e_addr[2], e_data[2], e_ta[2], e_sa[2];

  function automatic int dep(input int i);
    return (i == 0) ? 1024 : 16;
  endfunction

  function automatic int mstate(input int i);
    if (m_act[i] == 0) return 0;
    if (m_tn[i] < 0) return (m_n[i] < m_pre[i]) ? 1 : 2;
    return ((m_n[i] - m_tn[i] - 1) >= m_post[i]) ? 4 : 3;
  endfunction

  function automatic bit fires(input int i, input logic [7:0] s);
    bit lvl, edg;
    lvl = ((s ^ m_val[i]) & m_mask[i]) == 8'h00;
    edg = (m_edge[i] == 8'h00) || (m_pv[i] != 0 && ((s ^ m_prev[i]) & m_edge[i]) != 8'h00);
    return lvl && edg;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_n[i] = 0; m_tn[i] = -1; m_pv[i] = 0; m_pre[i] = 0; m_post[i] = 0;
      e_en[i] = 0; e_addr[i] = 0; e_data[i] = 0; e_ta[i] = 0; e_sa[i] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        int st;
        if (rst) begin
          m_act[i] = 0; m_n[i] = 0; m_tn[i] = -1; m_pv[i] = 0;
          e_en[i] = 0; e_addr[i] = 0; e_data[i] = 0; e_ta[i] = 0; e_sa[i] = 0;
        end else begin
          st = mstate(i);
          e_en[i] = 0;
          if (t_abort) begin
            m_act[i] = 0;
          end else if ((st == 0 || st == 4) && t_arm) begin
            m_act[i] = 1; m_n[i] = 0; m_tn[i] = -1; m_pv[i] = 0;
            m_pre[i] = int'(t_pre) % dep(i);
            m_post[i] = int'(t_post) % dep(i);
            m_mask[i] = t_mask; m_val[i] = t_value; m_edge[i] = t_edge;
          end else if (st >= 1 && st <= 3 && t_valid) begin
            e_en[i] = 1;
            e_addr[i] = m_n[i] % dep(i);
            e_data[i] = int'(t_data);
            if (st == 2 && fires(i, t_data)) begin
              m_tn[i] = m_n[i];
              e_ta[i] = m_n[i] % dep(i);
              e_sa[i] = ((m_n[i] - m_pre[i]) % dep(i) + dep(i)) % dep(i);
            end
            m_prev[i] = t_data;
            m_pv[i] = 1;
            m_n[i]++;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          int es, etr;
          es  = mstate(i);
          etr = (m_act[i] != 0 && m_tn[i] >= 0) ? 1 : 0;
          chk($sformatf("u%0d.state", i), d_st[i], es);
          chk($sformatf("u%0d.wr_en", i), d_en[i], e_en[i]);
          chk($sformatf("u%0d.triggered", i), d_tr[i], etr);
          chk($sformatf("u%0d.done", i), d_dn[i], (es == 4) ? 1 : 0);
          if (e_en[i] != 0) begin
            chk($sformatf("u%0d.wr_addr", i), d_addr[i], e_addr[i]);
            chk($sformatf("u%0d.wr_data", i), d_data[i], e_data[i]);
          end
          if (etr != 0) begin
            chk($sformatf("u%0d.trig_addr", i), d_ta[i], e_ta[i]);
            chk($sformatf("u%0d.start_addr", i), d_sa[i], e_sa[i]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic a, input logic ab, input logic v, input logic [7:0] d);
    t_arm = a; t_abort = ab; t_valid = v; t_data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input int pre, input int post, input logic [7:0] m,
                     input logic [7:0] v, input logic [7:0] e);
    t_pre = pre[9:0]; t_post = post[9:0]; t_mask = m; t_value = v; t_edge = e;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".state"}, d_st[0], 0);
    chk({tag, ".wr_en"}, d_en[0], 0);
    chk({tag, ".wr_addr"}, d_addr[0], 0);
    chk({tag, ".wr_data"}, d_data[0], 0);
    chk({tag, ".trig_addr"}, d_ta[0], 0);
    chk({tag, ".start_addr"}, d_sa[0], 0);
    chk({tag, ".triggered"}, d_tr[0], 0);
    chk({tag, ".done"}, d_dn[0], 0);
  endtask

  initial begin
    rst = 1'b1;
    t_arm = 0; t_abort = 0; t_valid = 0; t_data = 0;
    cfg(0, 0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset");
    chk("reset.u1.state", d_st[1], 0);
    rst = 1'b0;
    drive(0, 0, 0, 8'h00);

    // 1: ramp, level trigger on 0x10
    cfg(4, 3, 8'hFF, 8'h10, 8'h00);
    drive(1, 0, 1, 8'h77);
    for (int k = 0; k < 20; k++) drive(0, 0, 1, k[7:0]);
    chk("t1.trig_addr", d_ta[0], 16);
    chk("t1.start_addr", d_sa[0], 12);
    chk("t1.done", d_dn[0], 1);
    chk("t1.state", d_st[0], 4);
    chk("t1.u1.trig_addr", d_ta[1], 0);
    chk("t1.u1.start_addr", d_sa[1], 12);
    drive(0, 0, 1, 8'h55);
    chk("t1.done_hold", d_dn[0], 1);

    // 2: edge trigger, re-arm from DONE restarts at address 0
    cfg(0, 2, 8'h00, 8'h00, 8'h01);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h01);
    chk("t2.rearm_wr_en", d_en[0], 1);
    chk("t2.rearm_wr_addr", d_addr[0], 0);
    chk("t2.no_trig_1st", d_tr[0], 0);
    drive(0, 0, 1, 8'h01);
    chk("t2.no_trig_2nd", d_tr[0], 0);
    drive(0, 0, 1, 8'h00);
    chk("t2.trig_3rd", d_tr[0], 1);
    chk("t2.trig_addr", d_ta[0], 2);
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 1, 8'h00);
    chk("t2.done", d_dn[0], 1);

    // 3: wrap in the 16-deep instance
    cfg(2, 2, 8'hFF, 8'hAA, 8'h00);
    drive(1, 0, 0, 8'h00);
    for (int k = 0; k < 22; k++) begin
      drive(0, 0, 1, 8'h00);
      if (k == 16) begin
        chk("t3.u1.wrap_addr", d_addr[1], 0);
        chk("t3.u1.wrap_en", d_en[1], 1);
      end
    end
    drive(0, 0, 1, 8'hAA);
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 1, 8'h00);
    chk("t3.u1.trig_addr", d_ta[1], 6);
    chk("t3.u1.start_addr", d_sa[1], 4);
    chk("t3.u1.done", d_dn[1], 1);
    chk("t3.u0.trig_addr", d_ta[0], 22);
    chk("t3.u0.start_addr", d_sa[0], 20);

    // 4: abort in POST, then arm+abort together
    cfg(0, 5, 8'h00, 8'h00, 8'h00);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h01);
    drive(0, 0, 1, 8'h02);
    chk("t4.in_post", d_st[0], 3);
    drive(0, 1, 1, 8'h03);
    chk("t4.abort_state", d_st[0], 0);
    chk("t4.abort_wr_en", d_en[0], 0);
    chk("t4.abort_done", d_dn[0], 0);
    chk("t4.abort_trig", d_tr[0], 0);
    drive(1, 1, 1, 8'h04);
    chk("t4.arm_abort_state", d_st[0], 0);

    // 5: valid gaps, post=0
    cfg(3, 0, 8'hFF, 8'h05, 8'h00);
    drive(1, 0, 0, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 1, k[7:0]);
      if (k == 5) chk("t5.done_with_trig_write", d_dn[0] & d_en[0] & d_tr[0], 1);
      drive(0, 0, 0, 8'hEE);
    end
    chk("t5.trig_addr", d_ta[0], 4);
    chk("t5.state", d_st[0], 4);

    // 6: reset while ARMED
    cfg(0, 2, 8'hFF, 8'hFF, 8'h00);
    drive(1, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 8'h00);
    chk("t6.armed", d_st[0], 2);
    #1 rst = 1'b1;
    #1 chk_zero("t6.async_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    drive(0, 0, 0, 8'h00);

    // random phase: config inputs change every cycle to exercise latching
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cfg(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
          8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'h00);
      drive(r < 4, r >= 98, $urandom_range(0, 9) < 7, 8'($urandom_range(0, 3)));
    end

    drive(0, 0, 0, 8'h00);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
